// File: rtl/decode_pipe.sv
// Decode stage: register file with write-through bypass, load-use hazard
// detection with a single bubble, and the ID/EX pipeline register with
// valid/ready handshakes toward fetch and execute.
module decode_pipe #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [REG_AW-1:0] if_rs,
    input  logic [REG_AW-1:0] if_rt,
    input  logic [REG_AW-1:0] if_rd,
    input  logic              if_rs_used,
    input  logic              if_rt_used,
    input  logic              if_wen,
    input  logic              if_load,
    input  logic [DATA_W-1:0] if_imm,
    input  logic              if_err,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wen,
    output logic              ex_load,
    output logic              ex_err,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_wen;
    logic              r_ex_load;
    logic              r_ex_err;
    logic [DATA_W-1:0] r_ex_imm;
    logic [DATA_W-1:0] r_ex_pc;

    logic              w_wb_write;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_advance;
    logic              w_hazard;
    logic              w_rd_live;
    logic              w_refresh_rs;
    logic              w_refresh_rt;

    // Writes to the hardwired zero register are dropped when that mode is on.
    assign w_wb_write = wb_en && !((ZERO_REG != 0) && (wb_reg == '0));

    // Operand A read with same-cycle writeback bypass.
    always_comb begin
        w_rs_data = r_regs[if_rs];
        if (wb_en && (wb_reg == if_rs)) begin
            w_rs_data = wb_data;
        end
        if ((ZERO_REG != 0) && (if_rs == '0)) begin
            w_rs_data = '0;
        end
    end

    // Operand B read with same-cycle writeback bypass.
    always_comb begin
        w_rt_data = r_regs[if_rt];
        if (wb_en && (wb_reg == if_rt)) begin
            w_rt_data = wb_data;
        end
        if ((ZERO_REG != 0) && (if_rt == '0)) begin
            w_rt_data = '0;
        end
    end

    // A load targeting the zero register never produces a real value to wait on.
    assign w_rd_live = (ZERO_REG == 0) || (r_ex_rd != '0);
    assign w_hazard  = r_ex_valid && r_ex_load && r_ex_wen && w_rd_live &&
                       ((if_rs_used && (if_rs == r_ex_rd)) ||
                        (if_rt_used && (if_rt == r_ex_rd)));
    assign w_advance = !r_ex_valid || ex_ready;
    assign id_ready  = w_advance && !w_hazard && !flush;

    // Captured operands go stale if a writeback lands while execute is stalled.
    assign w_refresh_rs = w_wb_write && (wb_reg == r_ex_rs);
    assign w_refresh_rt = w_wb_write && (wb_reg == r_ex_rt);

    // Register file write port; writes proceed independent of stall and flush.
    // NOTE: the register file is cleared on reset because software relies on
    // all registers reading 0 after reset; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    // ID/EX pipeline register: flush beats capture, capture beats hold.
    // NOTE: all state here uses non-blocking assignments so every field
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_ex_wen     <= 1'b0;
            r_ex_load    <= 1'b0;
            r_ex_err     <= 1'b0;
            r_ex_imm     <= '0;
            r_ex_pc      <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_err   <= 1'b0;
        end else if (w_advance) begin
            if (if_valid && !w_hazard) begin
                r_ex_valid   <= 1'b1;
                r_ex_rs_data <= w_rs_data;
                r_ex_rt_data <= w_rt_data;
                r_ex_rs      <= if_rs;
                r_ex_rt      <= if_rt;
                r_ex_rd      <= if_rd;
                r_ex_wen     <= if_wen;
                r_ex_load    <= if_load;
                r_ex_err     <= if_err;
                r_ex_imm     <= if_imm;
                r_ex_pc      <= if_pc;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_err   <= 1'b0;
            end
        end else begin
            if (w_refresh_rs) begin
                r_ex_rs_data <= wb_data;
            end
            if (w_refresh_rt) begin
                r_ex_rt_data <= wb_data;
            end
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_rs_data = r_ex_rs_data;
    assign ex_rt_data = r_ex_rt_data;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_rd      = r_ex_rd;
    assign ex_wen     = r_ex_wen;
    assign ex_load    = r_ex_load;
    assign ex_err     = r_ex_err;
    assign ex_imm     = r_ex_imm;
    assign ex_pc      = r_ex_pc;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: a ZERO_REG=0 instance checked through
// a scoreboard of expected ID/EX contents, plus a ZERO_REG=1 instance sharing
// the same stimulus and checked directly for zero-register behaviour.
module tb_decode_pipe;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        wen;
        logic        load;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [2:0]  if_rs, if_rt, if_rd;
    logic        if_rs_used, if_rt_used, if_wen, if_load, if_err;
    logic [15:0] if_imm;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        ex_ready;

    logic        id_ready, ex_valid, ex_wen, ex_load, ex_err;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
    logic [2:0]  ex_rs, ex_rt, ex_rd;

    logic        z_id_ready, z_ex_valid, z_ex_wen, z_ex_load, z_ex_err;
    logic [15:0] z_ex_rs_data, z_ex_rt_data, z_ex_imm, z_ex_pc;
    logic [2:0]  z_ex_rs, z_ex_rt, z_ex_rd;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] model [8];

    decode_pipe #(.DATA_W(16), .REG_AW(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready),
        .if_pc(if_pc), .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd),
        .if_rs_used(if_rs_used), .if_rt_used(if_rt_used), .if_wen(if_wen),
        .if_load(if_load), .if_imm(if_imm), .if_err(if_err), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_load(ex_load), .ex_err(ex_err), .ex_imm(ex_imm), .ex_pc(ex_pc)
    );

    decode_pipe #(.DATA_W(16), .REG_AW(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(z_id_ready),
        .if_pc(if_pc), .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd),
        .if_rs_used(if_rs_used), .if_rt_used(if_rt_used), .if_wen(if_wen),
        .if_load(if_load), .if_imm(if_imm), .if_err(if_err), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .ex_ready(ex_ready),
        .ex_valid(z_ex_valid), .ex_rs_data(z_ex_rs_data), .ex_rt_data(z_ex_rt_data),
        .ex_rs(z_ex_rs), .ex_rt(z_ex_rt), .ex_rd(z_ex_rd), .ex_wen(z_ex_wen),
        .ex_load(z_ex_load), .ex_err(z_ex_err), .ex_imm(z_ex_imm), .ex_pc(z_ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference register read for the ZERO_REG=0 instance, including bypass.
    function automatic logic [15:0] model_read(input logic [2:0] sel);
        if (wb_en && (wb_reg == sel)) return wb_data;
        return model[sel];
    endfunction

    task automatic push_expect();
        exp_t e;
        e.pc      = if_pc;
        e.rs_data = model_read(if_rs);
        e.rt_data = model_read(if_rt);
        e.imm     = if_imm;
        e.rs      = if_rs;
        e.rt      = if_rt;
        e.rd      = if_rd;
        e.wen     = if_wen;
        e.load    = if_load;
        e.err     = if_err;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && wb_en) model[wb_reg] = wb_data;
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic present(input logic [15:0] pc, input logic [2:0] rs, input logic [2:0] rt,
                           input logic [2:0] rd, input logic rsu, input logic rtu,
                           input logic wen, input logic ld, input logic [15:0] imm,
                           input logic err);
        if_valid   = 1'b1;
        if_pc      = pc;
        if_rs      = rs;
        if_rt      = rt;
        if_rd      = rd;
        if_rs_used = rsu;
        if_rt_used = rtu;
        if_wen     = wen;
        if_load    = ld;
        if_imm     = imm;
        if_err     = err;
    endtask

    // Compare every instruction handed to execute against the scoreboard.
    always @(negedge clk) begin
        if (rst && ex_valid && ex_ready) begin
            check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("sb_pc",      32'(ex_pc),      32'(mon_e.pc));
                check("sb_rs_data", 32'(ex_rs_data), 32'(mon_e.rs_data));
                check("sb_rt_data", 32'(ex_rt_data), 32'(mon_e.rt_data));
                check("sb_imm",     32'(ex_imm),     32'(mon_e.imm));
                check("sb_rs",      32'(ex_rs),      32'(mon_e.rs));
                check("sb_rt",      32'(ex_rt),      32'(mon_e.rt));
                check("sb_rd",      32'(ex_rd),      32'(mon_e.rd));
                check("sb_wen",     32'(ex_wen),     32'(mon_e.wen));
                check("sb_load",    32'(ex_load),    32'(mon_e.load));
                check("sb_err",     32'(ex_err),     32'(mon_e.err));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        rst = 1'b0;
        ex_ready = 1'b1;
        idle();
        present(16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        if_valid = 1'b0;
        wb_reg = 3'd0;
        wb_data = 16'h0;
        #1;
        check("rst_ex_valid",   32'(ex_valid),   32'd0);
        check("rst_ex_pc",      32'(ex_pc),      32'd0);
        check("rst_ex_rs_data", 32'(ex_rs_data), 32'd0);
        check("rst_ex_err",     32'(ex_err),     32'd0);
        check("rst_id_ready",   32'(id_ready),   32'd1);
        check("rst_z_ex_valid", 32'(z_ex_valid), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Writeback then same-cycle bypass into the captured operand.
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234;
        #1;
        check("t1_id_ready_wb", 32'(id_ready), 32'd1);
        tick();
        present(16'h0010, 3'd3, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0);
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hBEEF;
        #1;
        check("t1_id_ready", 32'(id_ready), 32'd1);
        push_expect();
        tick();
        wb_en = 1'b0;
        check("t1_ex_valid", 32'(ex_valid),   32'd1);
        check("t1_bypass",   32'(ex_rs_data), 32'hBEEF);

        // Load followed by a dependent reader: one bubble.
        present(16'h0012, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
        #1;
        check("t2_ld_ready", 32'(id_ready), 32'd1);
        push_expect();
        tick();
        present(16'h0014, 3'd2, 3'd3, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0007, 1'b0);
        #1;
        check("t2_hazard_ready", 32'(id_ready), 32'd0);
        check("t2_valid_0",      32'(ex_valid), 32'd1);
        tick();
        check("t2_valid_1",      32'(ex_valid), 32'd0);
        check("t2_ready_after",  32'(id_ready), 32'd1);
        push_expect();
        tick();
        check("t2_valid_2",      32'(ex_valid), 32'd1);
        check("t2_dep_pc",       32'(ex_pc),    32'h0014);

        // Load followed by an instruction that reads nothing: no bubble.
        present(16'h0016, 3'd0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
        #1;
        push_expect();
        tick();
        present(16'h0018, 3'd6, 3'd6, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0018, 1'b0);
        #1;
        check("t3_id_ready", 32'(id_ready), 32'd1);
        push_expect();
        tick();
        check("t3_ex_valid", 32'(ex_valid), 32'd1);
        check("t3_ex_pc",    32'(ex_pc),    32'h0018);

        // Execute stalls three cycles; writeback to r5 refreshes ex_rt_data.
        present(16'h001A, 3'd1, 3'd5, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 16'h001A, 1'b0);
        #1;
        push_expect();
        tick();
        ex_ready = 1'b0;
        present(16'h001C, 3'd5, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h001C, 1'b0);
        wb_en = 1'b1; wb_reg = 3'd5; wb_data = 16'h00AA;
        sb_q[$].rt_data = 16'h00AA;
        #1;
        check("t4_ready_hold0", 32'(id_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        #1;
        check("t4_ready_hold1", 32'(id_ready),   32'd0);
        check("t4_refresh",     32'(ex_rt_data), 32'h00AA);
        tick();
        check("t4_hold_pc",     32'(ex_pc),      32'h001A);
        tick();
        ex_ready = 1'b1;
        #1;
        check("t4_release_ready", 32'(id_ready), 32'd1);
        push_expect();
        tick();
        check("t4_next_pc", 32'(ex_pc), 32'h001C);

        // Flush drops the presented instruction; writeback still lands.
        present(16'h001E, 3'd7, 3'd7, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        flush = 1'b1;
        wb_en = 1'b1; wb_reg = 3'd4; wb_data = 16'h5A5A;
        #1;
        check("t5_id_ready", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b0;
        wb_en = 1'b0;
        check("t5_ex_valid", 32'(ex_valid), 32'd0);
        present(16'h0020, 3'd4, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b1);
        #1;
        check("t5_ready_after", 32'(id_ready), 32'd1);
        push_expect();
        tick();
        check("t5_wb_landed", 32'(ex_rs_data), 32'h5A5A);
        check("t5_err",       32'(ex_err),     32'd1);
        idle();
        tick();
        check("bubble_valid", 32'(ex_valid), 32'd0);
        check("bubble_err",   32'(ex_err),   32'd0);

        // Zero register: discarded write, reads 0, load to r0 never stalls.
        wb_en = 1'b1; wb_reg = 3'd0; wb_data = 16'hFFFF;
        tick();
        wb_en = 1'b0;
        present(16'h0022, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);
        #1;
        push_expect();
        tick();
        check("t6_z_rs_data",  32'(z_ex_rs_data), 32'h0000);
        check("t6_nz_rs_data", 32'(ex_rs_data),   32'hFFFF);
        present(16'h0024, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        #1;
        check("t6_z_ready",  32'(z_id_ready), 32'd1);
        check("t6_nz_ready", 32'(id_ready),   32'd0);
        tick();
        check("t6_z_valid",   32'(z_ex_valid),   32'd1);
        check("t6_z_pc",      32'(z_ex_pc),      32'h0024);
        check("t6_z_rs_read", 32'(z_ex_rs_data), 32'h0000);
        check("t6_nz_bubble", 32'(ex_valid),     32'd0);
        push_expect();
        tick();
        idle();
        tick();

        // Asynchronous reset mid-operation clears ex_valid before any edge.
        present(16'h0030, 3'd3, 3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 1'b0);
        #1;
        push_expect();
        tick();
        idle();
        ex_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mr_ex_valid",   32'(ex_valid),   32'd0);
        check("mr_id_ready",   32'(id_ready),   32'd1);
        check("mr_z_ex_valid", 32'(z_ex_valid), 32'd0);
        void'(sb_q.pop_back());
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        tick();
        rst = 1'b1;
        ex_ready = 1'b1;
        present(16'h0032, 3'd3, 3'd4, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        #1;
        push_expect();
        tick();
        idle();
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
